// File: rtl/programmable_interconnect_router_if.sv
// Bundle of PIA inputs, serial configuration handshake and registered LAB outputs
// for the programmable interconnect router.
interface programmable_interconnect_router_if #(
   parameter int unsigned LAB_COUNT            = 2,
   parameter int unsigned NUM_IO_PINS          = 32,
   parameter int unsigned NUM_MACROCELLS       = 32,
   parameter int unsigned NUM_DEDICATED_INPUTS = 4,
   parameter int unsigned SIGNALS_PER_LAB      = 36
);
   logic [NUM_DEDICATED_INPUTS-1:0]        dedicated_input_signals;
   logic [NUM_MACROCELLS-1:0]              macrocell_output_signals;
   logic [NUM_IO_PINS-1:0]                 io_pin_signals;
   logic                                   cfg_start;
   logic                                   cfg_valid;
   logic                                   cfg_data;
   logic                                   cfg_commit;
   logic                                   cfg_ready;
   logic                                   cfg_done;
   logic [LAB_COUNT*SIGNALS_PER_LAB-1:0]   lab_signals;

   modport master (
      output dedicated_input_signals, macrocell_output_signals, io_pin_signals,
      output cfg_start, cfg_valid, cfg_data, cfg_commit,
      input  cfg_ready, cfg_done, lab_signals
   );

   modport slave (
      input  dedicated_input_signals, macrocell_output_signals, io_pin_signals,
      input  cfg_start, cfg_valid, cfg_data, cfg_commit,
      output cfg_ready, cfg_done, lab_signals
   );
endinterface

// File: rtl/programmable_interconnect_router.sv
// PIA router: every LAB slot registers one PIA signal chosen by an active selector.
// Selectors are reloaded through a serial shadow chain and swapped in atomically on commit.
module programmable_interconnect_router #(
   parameter int unsigned LAB_COUNT            = 2,
   parameter int unsigned NUM_IO_PINS          = 32,
   parameter int unsigned NUM_MACROCELLS       = 32,
   parameter int unsigned NUM_DEDICATED_INPUTS = 4,
   parameter int unsigned SIGNALS_PER_LAB      = 36,
   parameter int unsigned SEL_WIDTH            = 7
) (
   input  logic clock,
   input  logic reset_n,
   programmable_interconnect_router_if.slave bus
);

   localparam int unsigned N           = NUM_DEDICATED_INPUTS + NUM_MACROCELLS + NUM_IO_PINS;
   localparam int unsigned NUM_ENTRIES = LAB_COUNT * SIGNALS_PER_LAB;
   localparam int unsigned CHAIN_LEN   = NUM_ENTRIES * SEL_WIDTH;
   localparam int unsigned CNT_W       = $clog2(CHAIN_LEN + 1);
   localparam int unsigned SEL_SPACE   = 2 ** SEL_WIDTH;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {StIdle, StShift, StReady} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0]     shadow_q, shadow_d;
   logic [CHAIN_LEN-1:0]     sel_q, sel_d;
   logic [NUM_ENTRIES-1:0]   lab_q, lab_d;
   logic                     done_q;

   logic                     shift_en;
   logic                     commit_en;
   logic                     cnt_clr;
   logic                     ready;

   logic [N-1:0]             pia;
   logic [SEL_SPACE-1:0]     pia_ext;

   // Selector codes at or above N land in the zero padding, so they route a constant 0.
   assign pia     = {bus.io_pin_signals, bus.macrocell_output_signals,
                     bus.dedicated_input_signals};
   assign pia_ext = {{(SEL_SPACE - N){1'b0}}, pia};

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; cfg_start overrides everything else in any state
   always_comb begin
      state_d = state_q;
      if (bus.cfg_start) begin
         state_d = StShift;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StShift: if (shift_en && (cnt_q == LAST_BIT)) state_d = StReady;
            StReady: if (bus.cfg_commit) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      cnt_clr   = bus.cfg_start;
      shift_en  = !bus.cfg_start && (state_q == StShift) && bus.cfg_valid;
      commit_en = !bus.cfg_start && (state_q == StReady) && bus.cfg_commit;
      ready     = (state_q == StReady);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (shift_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      if (shift_en) begin
         shadow_d = {bus.cfg_data, shadow_q[CHAIN_LEN-1:1]};
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (commit_en) begin
         sel_d = shadow_q;
      end
   end

   always_comb begin
      lab_d = '0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         lab_d[k] = pia_ext[sel_q[k*SEL_WIDTH +: SEL_WIDTH]];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         shadow_q <= '1;
         sel_q    <= '1;
         lab_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         sel_q    <= sel_d;
         lab_q    <= lab_d;
         done_q   <= commit_en;
      end
   end

   assign bus.cfg_ready   = ready;
   assign bus.cfg_done    = done_q;
   assign bus.lab_signals = lab_q;

endmodule

// File: tb/tb_programmable_interconnect_router.sv
// Scoreboard bench: a selector model predicts lab_signals for each driven input pattern.
module tb_programmable_interconnect_router;

   localparam int LABS = 2;
   localparam int NIO  = 32;
   localparam int NMC  = 32;
   localparam int NDI  = 4;
   localparam int SPL  = 36;
   localparam int SW   = 7;
   localparam int N    = NDI + NMC + NIO;
   localparam int NE   = LABS * SPL;
   localparam int L    = NE * SW;

   logic clock;
   logic reset_n;

   programmable_interconnect_router_if #(
      .LAB_COUNT(LABS), .NUM_IO_PINS(NIO), .NUM_MACROCELLS(NMC),
      .NUM_DEDICATED_INPUTS(NDI), .SIGNALS_PER_LAB(SPL)
   ) bus ();

   programmable_interconnect_router #(
      .LAB_COUNT(LABS), .NUM_IO_PINS(NIO), .NUM_MACROCELLS(NMC),
      .NUM_DEDICATED_INPUTS(NDI), .SIGNALS_PER_LAB(SPL), .SEL_WIDTH(SW)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;
   int model_sel[NE];
   int pend_sel[NE];
   logic [NE-1:0] exp_q[$];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [NE-1:0] model_lab(input logic [NDI-1:0] d, input logic [NMC-1:0] m,
                                               input logic [NIO-1:0] io);
      logic [N-1:0] pia;
      logic [NE-1:0] r;
      pia = {io, m, d};
      r = '0;
      for (int k = 0; k < NE; k++) begin
         if (model_sel[k] < N) r[k] = pia[model_sel[k]];
      end
      return r;
   endfunction

   task automatic route_cycle(input string name, input logic [NDI-1:0] d,
                              input logic [NMC-1:0] m, input logic [NIO-1:0] io);
      logic [NE-1:0] exp_v;
      bus.dedicated_input_signals  = d;
      bus.macrocell_output_signals = m;
      bus.io_pin_signals           = io;
      exp_q.push_back(model_lab(d, m, io));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.lab_signals !== exp_v)
         $display("FAIL %s: lab_signals got %h want %h", name, bus.lab_signals, exp_v);
      else passed++;
   endtask

   task automatic route_random(input string name, input int n);
      for (int i = 0; i < n; i++)
         route_cycle(name, NDI'($urandom_range(0, 15)), $urandom, $urandom);
   endtask

   task automatic clear_inputs();
      bus.dedicated_input_signals  = '0;
      bus.macrocell_output_signals = '0;
      bus.io_pin_signals           = '0;
      bus.cfg_start  = 1'b0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_data   = 1'b0;
      bus.cfg_commit = 1'b0;
   endtask

   task automatic pend_unrouted();
      for (int k = 0; k < NE; k++) pend_sel[k] = 127;
   endtask

   task automatic start_load();
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
   endtask

   task automatic shift_bits(input int first, input int last);
      for (int b = first; b < last; b++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = 1'((pend_sel[b / SW] >> (b % SW)) & 1);
         tick();
      end
      bus.cfg_valid = 1'b0;
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) $display("FAIL %s: got %b want %b", name, got, want);
      else passed++;
   endtask

   task automatic commit_expect_done(input string name);
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_commit = 1'b0;
      for (int k = 0; k < NE; k++) model_sel[k] = pend_sel[k];
      check_bit({name, " done pulse"}, bus.cfg_done, 1'b1);
      check_bit({name, " ready after commit"}, bus.cfg_ready, 1'b0);
      tick();
      check_bit({name, " done single"}, bus.cfg_done, 1'b0);
   endtask

   task automatic full_load(input string name);
      start_load();
      shift_bits(0, L);
      check_bit({name, " ready"}, bus.cfg_ready, 1'b1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      for (int k = 0; k < NE; k++) model_sel[k] = 127;
      repeat (2) tick();
      checks++;
      if (bus.lab_signals !== '0) $display("FAIL reset lab: got %h want 0", bus.lab_signals);
      else passed++;
      check_bit("reset ready", bus.cfg_ready, 1'b0);
      check_bit("reset done", bus.cfg_done, 1'b0);
      reset_n = 1'b1;
      tick();
      route_cycle("reset toggle ones", '1, '1, '1);
      route_random("reset toggle rand", 4);
      bus.cfg_valid  = 1'b1;
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_valid  = 1'b0;
      bus.cfg_commit = 1'b0;
      check_bit("idle commit ignored", bus.cfg_done, 1'b0);
      check_bit("idle ready", bus.cfg_ready, 1'b0);
   endtask

   task automatic test_route();
      pend_unrouted();
      pend_sel[0]  = 0;
      pend_sel[36] = 67;
      full_load("route");
      commit_expect_done("route");
      route_cycle("route ded0 io31", 4'b0001, '0, 32'h8000_0000);
      checks++;
      if (bus.lab_signals !== ((72'd1 << 36) | 72'd1))
         $display("FAIL route fixed: got %h want bits 0 and 36", bus.lab_signals);
      else passed++;
      route_random("route rand", 4);
   endtask

   task automatic test_unrouted();
      pend_unrouted();
      pend_sel[5] = 100;
      pend_sel[6] = 4;
      pend_sel[40] = 37;
      full_load("unrouted");
      commit_expect_done("unrouted");
      route_cycle("unrouted all ones", '1, '1, '1);
      check_bit("unrouted slot5", bus.lab_signals[5], 1'b0);
      route_random("unrouted rand", 3);
   endtask

   task automatic test_restart();
      for (int k = 0; k < NE; k++) pend_sel[k] = k % N;
      start_load();
      shift_bits(0, 200);
      route_random("shift old sel", 2);
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_commit = 1'b0;
      check_bit("commit in shift ignored", bus.cfg_done, 1'b0);
      tick();
      check_bit("commit in shift no done", bus.cfg_done, 1'b0);
      for (int k = 0; k < NE; k++) pend_sel[k] = (k * 5 + 3) % N;
      full_load("restart");
      route_random("ready old sel", 2);
      commit_expect_done("restart");
      route_random("restart rand", 5);
   endtask

   task automatic test_reset_mid_load();
      for (int k = 0; k < NE; k++) pend_sel[k] = (k * 7 + 1) % N;
      start_load();
      shift_bits(0, 300);
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < NE; k++) model_sel[k] = 127;
      checks++;
      if (bus.lab_signals !== '0) $display("FAIL async reset lab: got %h want 0", bus.lab_signals);
      else passed++;
      check_bit("async reset ready", bus.cfg_ready, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_commit = 1'b0;
      check_bit("post reset commit", bus.cfg_done, 1'b0);
      shift_bits(0, 4);
      check_bit("post reset idle", bus.cfg_ready, 1'b0);
      route_random("post reset rand", 3);
   endtask

   task automatic test_start_commit();
      for (int k = 0; k < NE; k++) pend_sel[k] = (k * 11 + 2) % N;
      full_load("stcm");
      commit_expect_done("stcm");
      for (int k = 0; k < NE; k++) pend_sel[k] = (k * 3 + 9) % N;
      full_load("stcm second");
      bus.cfg_start  = 1'b1;
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_start  = 1'b0;
      bus.cfg_commit = 1'b0;
      check_bit("start+commit done", bus.cfg_done, 1'b0);
      check_bit("start+commit ready", bus.cfg_ready, 1'b0);
      route_random("start+commit old sel", 2);
      shift_bits(0, L - 1);
      check_bit("counter cleared", bus.cfg_ready, 1'b0);
      shift_bits(L - 1, L);
      check_bit("counter full", bus.cfg_ready, 1'b1);
      commit_expect_done("stcm final");
      route_random("stcm rand", 4);
   endtask

   initial begin
      test_reset();
      test_route();
      test_unrouted();
      test_restart();
      test_reset_mid_load();
      test_start_commit();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/programmable_interconnect_router.md
PROGRAMMABLE_INTERCONNECT_ROUTER -- requirements
Module: programmable_interconnect_router

Interface
REQ-001 Parameter LAB_COUNT, default 2: number of logic array blocks served.
REQ-002 Parameter NUM_IO_PINS, default 32: I/O pin signals feeding the array.
REQ-003 Parameter NUM_MACROCELLS, default 32: macrocell output signals feeding the array.
REQ-004 Parameter NUM_DEDICATED_INPUTS, default 4: dedicated input signals feeding the array.
REQ-005 Parameter SIGNALS_PER_LAB, default 36: regional signals selected per LAB.
REQ-006 Parameter SEL_WIDTH, default 7: selector width; 2^SEL_WIDTH SHALL exceed N = NUM_DEDICATED_INPUTS+NUM_MACROCELLS+NUM_IO_PINS (68 by default).
REQ-007 clock  in  1  single clock; all state changes on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 dedicated_input_signals  in  NUM_DEDICATED_INPUTS  dedicated inputs.
REQ-010 macrocell_output_signals  in  NUM_MACROCELLS  macrocell outputs.
REQ-011 io_pin_signals  in  NUM_IO_PINS  I/O pin inputs.
REQ-012 cfg_start  in  1  pulse; begins or restarts a configuration load.
REQ-013 cfg_valid  in  1  qualifies cfg_data for one shift.
REQ-014 cfg_data  in  1  serial selector bit.
REQ-015 cfg_commit  in  1  pulse; activates the loaded configuration.
REQ-016 cfg_ready  out  1  high while a complete chain awaits commit.
REQ-017 cfg_done  out  1  one-cycle pulse on the cycle after a commit is accepted.
REQ-018 lab_signals  out  LAB_COUNT*SIGNALS_PER_LAB  registered regional signals; entry k = LAB k/SIGNALS_PER_LAB, slot k%SIGNALS_PER_LAB.

Function
REQ-019 Internal PIA bus of width N SHALL be {io_pin_signals, macrocell_output_signals, dedicated_input_signals}, dedicated inputs at index 0 upward.
REQ-020 Each output entry k SHALL have an active selector sel[k]; lab_signals[k] SHALL register pia[sel[k]] every cycle (latency 1 clock).
REQ-021 If sel[k] >= N, lab_signals[k] SHALL register 0 (unrouted).
REQ-022 A shadow chain of L = LAB_COUNT*SIGNALS_PER_LAB*SEL_WIDTH bits and a bit counter SHALL hold the pending configuration; entry k occupies chain bits [(k+1)*SEL_WIDTH-1 : k*SEL_WIDTH].
REQ-023 Each shift SHALL move the chain one bit toward LSB with cfg_data entering at bit L-1; after L shifts the first bit sent sits at bit 0.
REQ-024 FSM states: IDLE, SHIFT, READY.
REQ-025 IDLE: cfg_start -> SHIFT, counter cleared; cfg_valid and cfg_commit ignored.
REQ-026 SHIFT: cfg_valid shifts one bit and increments counter; the shift bringing counter to L -> READY.
REQ-027 cfg_start in SHIFT or READY SHALL clear the counter and re-enter SHIFT, discarding the partial or pending load; cfg_start wins over simultaneous cfg_valid or cfg_commit.
REQ-028 READY: cfg_ready=1; further cfg_valid ignored; cfg_commit copies all shadow entries to active selectors in one cycle -> IDLE, cfg_done pulses next cycle.
REQ-029 cfg_commit outside READY SHALL be ignored, no cfg_done.
REQ-030 Output from the commit edge onward SHALL use the new selectors; lab_signals reflects them one clock after commit.
REQ-031 Routing SHALL continue uninterrupted with the old selectors during SHIFT and READY.

Reset
REQ-032 reset_n low SHALL immediately force: FSM IDLE, counter 0, shadow chain all ones, active selectors all ones (unrouted), lab_signals 0, cfg_ready 0, cfg_done 0.
REQ-033 Reset asserted mid-load SHALL discard the load; no partial configuration becomes active.

Verification
REQ-034 Reset then toggle all inputs -> lab_signals stays 0, cfg_ready 0.
REQ-035 cfg_start, shift 504 bits placing entry 0 = 0 and entry 36 = 67, commit; drive dedicated_input_signals[0]=1, io_pin_signals[31]=1 -> cfg_done one pulse, one clock later lab_signals[0]=1 and lab_signals[36]=1, all else 0.
REQ-036 Load entry 5 = 100 (out of range), commit, drive all inputs 1 -> lab_signals[5]=0.
REQ-037 Shift 200 bits, cfg_start, shift full 504-bit chain, commit -> only second chain active; commit attempted at bit 200 produces no cfg_done.
REQ-038 Assert reset_n low at bit 300 of a load -> outputs 0, FSM IDLE; cfg_commit afterwards ignored.
REQ-039 cfg_start and cfg_commit same cycle in READY -> no commit, cfg_ready drops, FSM in SHIFT with counter 0.
